move_list_reader: RTL and testbench



---
 rtl/chess_pkg.sv | 55 +++++
 rtl/move_list_reader_if.sv | 34 +++
 rtl/move_list_reader.sv | 147 ++++++++++++++
 tb/tb_move_list_reader.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess move-generation definitions: move word layout, flag bit
// positions, piece codes, list-reader state encoding and slot helpers.
package chess_pkg;

   localparam int MOVE_W = 19;
   localparam int SLOTS  = 8;
   localparam int WORD_W = MOVE_W * SLOTS;

   // Flag bit positions inside a 19-bit move: [18:12] flags, [11:6] from, [5:0] to
   localparam int FLAG_INVALID = 18;
   localparam int FLAG_PROMOTE = 17;
   localparam int FLAG_PAWN    = 16;
   localparam int FLAG_PAWN2   = 15;
   localparam int FLAG_EP      = 14;
   localparam int FLAG_CASTLE  = 13;
   localparam int FLAG_CAPTURE = 12;

   typedef enum logic [2:0] {
      PC_EMPTY  = 3'd0,
      PC_PAWN   = 3'd1,
      PC_KNIGHT = 3'd2,
      PC_BISHOP = 3'd3,
      PC_ROOK   = 3'd4,
      PC_QUEEN  = 3'd5,
      PC_KING   = 3'd6
   } piece_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_DONE = 3'd1,
      ST_READ      = 3'd2,
      ST_LATCH     = 3'd3,
      ST_EMIT      = 3'd4,
      ST_FINISH    = 3'd5
   } state_t;

   typedef logic [MOVE_W-1:0] move_t;
   typedef logic [WORD_W-1:0] word_t;

   // Slot 0 sits in the most significant bits and is emitted first.
   function automatic move_t slot_of(input word_t w, input logic [2:0] idx);
      return w[MOVE_W*(SLOTS-1-int'(idx)) +: MOVE_W];
   endfunction

   // A word whose every slot carries the invalid flag terminates the list.
   function automatic logic word_is_marker(input word_t w);
      logic m;
      m = 1'b1;
      for (int i = 0; i < SLOTS; i++) begin
         m = m & w[MOVE_W*i + FLAG_INVALID];
      end
      return m;
   endfunction

endpackage

// File: rtl/move_list_reader_if.sv
// Bundle of the list reader's control, FIFO and move-stream signals.
// Move stream handshake: a move transfers on every rising clk edge where
// mv_valid && mv_ready; while mv_valid && !mv_ready the reader holds
// mv_data stable, and mv_valid never drops without a transfer (except reset).
interface move_list_reader_if #(
   parameter int CNT_W = 8
);
   logic                        start;
   logic                        sq_done;
   logic [chess_pkg::WORD_W-1:0] fifo_data;
   logic                        fifo_rden;
   logic                        mv_valid;
   logic                        mv_ready;
   logic [chess_pkg::MOVE_W-1:0] mv_data;
   logic                        busy;
   logic                        list_done;
   logic                        overflow;
   logic [CNT_W-1:0]            mv_count;
   chess_pkg::state_t           state;

   // Controller / square-unit side
   modport master (
      output start, sq_done, fifo_data, mv_ready,
      input  fifo_rden, mv_valid, mv_data, busy, list_done, overflow,
             mv_count, state
   );

   // List reader side
   modport slave (
      input  start, sq_done, fifo_data, mv_ready,
      output fifo_rden, mv_valid, mv_data, busy, list_done, overflow,
             mv_count, state
   );
endinterface

// File: rtl/move_list_reader.sv
// Reads one square's move list out of the square FIFO word by word, streams
// the valid 19-bit moves downstream and stops at an all-invalid end marker
// or, if that never arrives, after MAX_WORDS words with overflow raised.
module move_list_reader
   import chess_pkg::*;
#(
   parameter int MAX_WORDS = 32,
   parameter int CNT_W     = 8
) (
   input logic                clk,
   input logic                reset_n,
   move_list_reader_if.slave  bus
);

   localparam int              WCNT_W  = $clog2(MAX_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t              state;
   state_t              state_nx;
   word_t               word_q;
   logic [2:0]          slot_q;
   logic [WCNT_W-1:0]   word_cnt;
   logic                ovf_q;
   logic [CNT_W-1:0]    cnt_q;

   move_t               cur_slot;
   logic                cur_valid;
   logic                slot_adv;
   logic                last_slot;
   logic                word_limit;

   logic                fifo_rden_c;
   logic                mv_valid_c;
   move_t               mv_data_c;
   logic                busy_c;
   logic                list_done_c;

   assign cur_slot   = slot_of(word_q, slot_q);
   assign cur_valid  = ~cur_slot[FLAG_INVALID];
   // Invalid slots leave in one cycle; valid ones wait for the handshake.
   assign slot_adv   = (state == ST_EMIT) && (!cur_valid || bus.mv_ready);
   assign last_slot  = (slot_q == 3'(SLOTS - 1));
   assign word_limit = (word_cnt == WCNT_W'(MAX_WORDS));

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (bus.start) state_nx = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (bus.sq_done) state_nx = ST_READ;
         end
         ST_READ: begin
            state_nx = ST_LATCH;
         end
         ST_LATCH: begin
            if (word_is_marker(bus.fifo_data)) state_nx = ST_FINISH;
            else                               state_nx = ST_EMIT;
         end
         ST_EMIT: begin
            if (slot_adv && last_slot) begin
               if (word_limit) state_nx = ST_FINISH;
               else            state_nx = ST_READ;
            end
         end
         ST_FINISH: begin
            state_nx = ST_IDLE;
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   // Datapath: captured word, slot pointer, word/move counters, overflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q   <= '0;
         slot_q   <= '0;
         word_cnt <= '0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         if (state == ST_IDLE && bus.start) begin
            word_cnt <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
         end
         if (state == ST_LATCH) begin
            word_q   <= bus.fifo_data;
            word_cnt <= word_cnt + WCNT_W'(1);
            slot_q   <= '0;
         end
         if (slot_adv) begin
            slot_q <= slot_q + 3'd1;
            if (cur_valid && cnt_q != CNT_MAX) begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
            if (last_slot && word_limit) begin
               ovf_q <= 1'b1;
            end
         end
      end
   end

   // Output decode from the current state
   always_comb begin
      fifo_rden_c = 1'b0;
      mv_valid_c  = 1'b0;
      mv_data_c   = '0;
      busy_c      = 1'b1;
      list_done_c = 1'b0;
      case (state)
         ST_IDLE:   busy_c      = 1'b0;
         ST_READ:   fifo_rden_c = 1'b1;
         ST_EMIT: begin
            mv_valid_c = cur_valid;
            if (cur_valid) mv_data_c = cur_slot;
         end
         ST_FINISH: list_done_c = 1'b1;
         default: begin
            busy_c = 1'b1;
         end
      endcase
   end

   assign bus.fifo_rden = fifo_rden_c;
   assign bus.mv_valid  = mv_valid_c;
   assign bus.mv_data   = mv_data_c;
   assign bus.busy      = busy_c;
   assign bus.list_done = list_done_c;
   assign bus.overflow  = ovf_q;
   assign bus.mv_count  = cnt_q;
   assign bus.state     = state;

endmodule

// File: tb/tb_move_list_reader.sv
// Bench for move_list_reader: directed scenarios plus randomized move lists
// compared against a list-level reference model.
module tb_move_list_reader;
   import chess_pkg::*;

   localparam int MAXW = 2;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   // Clock and reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   move_list_reader_if #(.CNT_W(CW)) bus();

   move_list_reader #(.MAX_WORDS(MAXW), .CNT_W(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // Scoreboard state
   int          n_checks = 0;
   int          n_pass   = 0;
   logic [MOVE_W-1:0] exp_q[$];
   logic [WORD_W-1:0] fifo_q[$];
   int          exp_words;
   logic        exp_ovf;
   int          exp_cnt;
   int          fifo_base, obs_base, done_base, stall_base;

   // Observation state (owned by the monitor)
   logic [MOVE_W-1:0] obs_q[$];
   int          rden_cnt  = 0;
   int          done_cnt  = 0;
   int          stall_err = 0;
   logic        prev_stall = 1'b0;
   logic [MOVE_W-1:0] prev_data = '0;

   // Ready driver controls
   int          ready_mode   = 0;
   logic        ready_manual = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // FIFO responder and output monitor
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!bus.mv_valid || bus.mv_data !== prev_data)) stall_err++;
         prev_stall = bus.mv_valid && !bus.mv_ready;
         prev_data  = bus.mv_data;
         if (bus.mv_valid && bus.mv_ready) obs_q.push_back(bus.mv_data);
         if (bus.list_done) done_cnt++;
         if (bus.fifo_rden) begin
            if (rden_cnt - fifo_base < fifo_q.size()) bus.fifo_data = fifo_q[rden_cnt - fifo_base];
            else bus.fifo_data = '1;
            rden_cnt++;
         end
      end
   end

   // Downstream ready driver
   always begin
      @(posedge clk);
      #1;
      if (ready_mode == 0)      bus.mv_ready = 1'b1;
      else if (ready_mode == 1) bus.mv_ready = ($urandom_range(0, 9) < 6);
      else                      bus.mv_ready = ready_manual;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [MOVE_W-1:0] rand_move(input logic invalid);
      logic [17:0] r;
      r = 18'($urandom());
      return {invalid, r};
   endfunction

   function automatic logic [WORD_W-1:0] rand_word(input int density, input logic marker);
      logic [WORD_W-1:0] w;
      logic              any;
      any = 1'b0;
      w = '0;
      for (int s = 0; s < SLOTS; s++) begin
         logic v;
         v = !marker && ($urandom_range(0, 7) < density);
         any = any | v;
         w[MOVE_W*(SLOTS-1-s) +: MOVE_W] = rand_move(!v);
      end
      if (!marker && !any) begin
         int s;
         s = $urandom_range(0, SLOTS-1);
         w[MOVE_W*(SLOTS-1-s) + FLAG_INVALID] = 1'b0;
      end
      return w;
   endfunction

   // Reference model: walk the queued words as a list
   task automatic model_list();
      logic [WORD_W-1:0] w;
      logic [MOVE_W-1:0] mv;
      logic              ended;
      logic              any;
      exp_q.delete();
      exp_ovf   = 1'b0;
      exp_words = 0;
      ended     = 1'b0;
      for (int i = 0; i < fifo_q.size() && !ended; i++) begin
         w = fifo_q[i];
         exp_words++;
         any = 1'b0;
         for (int s = 0; s < SLOTS; s++) begin
            mv = w[MOVE_W*(SLOTS-1-s) +: MOVE_W];
            if (!mv[FLAG_INVALID]) begin
               exp_q.push_back(mv);
               any = 1'b1;
            end
         end
         if (!any) ended = 1'b1;
         else if (exp_words == MAXW) begin
            exp_ovf = 1'b1;
            ended   = 1'b1;
         end
      end
      if (!ended) exp_words++;
      exp_cnt = (exp_q.size() > CMAX) ? CMAX : exp_q.size();
   endtask

   task automatic start_list(input int sq_delay);
      fifo_base  = rden_cnt;
      obs_base   = obs_q.size();
      done_base  = done_cnt;
      stall_base = stall_err;
      model_list();
      bus.sq_done = 1'b0;
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      check("busy_after_start", bus.busy, 1);
      if (sq_delay >= 0) begin
         repeat (sq_delay) tick();
         bus.sq_done = 1'b1;
      end
   endtask

   task automatic finish_list();
      int guard;
      guard = 0;
      while (done_cnt == done_base && guard < 600) begin
         tick();
         guard++;
      end
      check("list_done_seen", done_cnt != done_base, 1);
      repeat (3) tick();
      bus.sq_done = 1'b0;
      check("list_done_pulses", done_cnt - done_base, 1);
      check("rden_pulses", rden_cnt - fifo_base, exp_words);
      check("move_total", obs_q.size() - obs_base, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (obs_base + i < obs_q.size()) check("move_data", obs_q[obs_base + i], exp_q[i]);
      end
      check("mv_count", bus.mv_count, exp_cnt);
      check("overflow", bus.overflow, exp_ovf);
      check("busy_idle", bus.busy, 0);
      check("stall_stable", stall_err - stall_base, 0);
   endtask

   task automatic wait_valid(input string tag);
      int guard;
      guard = 0;
      while (!bus.mv_valid && guard < 100) begin
         tick();
         guard++;
      end
      check(tag, bus.mv_valid, 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rden"},     bus.fifo_rden, 0);
      check({tag, "_valid"},    bus.mv_valid, 0);
      check({tag, "_busy"},     bus.busy, 0);
      check({tag, "_done"},     bus.list_done, 0);
      check({tag, "_overflow"}, bus.overflow, 0);
      check({tag, "_count"},    bus.mv_count, 0);
      check({tag, "_data"},     bus.mv_data, 0);
   endtask

   function automatic logic [WORD_W-1:0] fill_word(input logic [MOVE_W-1:0] fill);
      logic [WORD_W-1:0] w;
      for (int s = 0; s < SLOTS; s++) w[MOVE_W*(SLOTS-1-s) +: MOVE_W] = fill;
      return w;
   endfunction

   initial begin
      logic [WORD_W-1:0] w;
      logic [MOVE_W-1:0] v;
      bus.start     = 1'b0;
      bus.sq_done   = 1'b0;
      fifo_base     = 0;

      // Reset state
      repeat (3) tick();
      check_all_zero("reset_held");
      reset_n = 1'b1;
      tick();
      check_all_zero("reset_released");

      // Two moves in slots 0 and 3, then end marker
      ready_mode = 0;
      fifo_q.delete();
      w = fill_word(19'h40000);
      w[MOVE_W*7 +: MOVE_W] = 19'h0_0C1B;
      w[MOVE_W*4 +: MOVE_W] = 19'h0_1000;
      fifo_q.push_back(w);
      fifo_q.push_back(rand_word(0, 1'b1));
      start_list(1);
      finish_list();
      check("two_move_count", bus.mv_count, 2);

      // Backpressure: ready low for 5 cycles
      ready_mode = 2;
      ready_manual = 1'b0;
      fifo_q.delete();
      v = rand_move(1'b0);
      w = fill_word(19'h7FFFF);
      w[MOVE_W*7 +: MOVE_W] = v;
      fifo_q.push_back(w);
      fifo_q.push_back(rand_word(0, 1'b1));
      start_list(0);
      wait_valid("stall_valid_seen");
      for (int k = 0; k < 5; k++) begin
         check("stall_valid", bus.mv_valid, 1);
         check("stall_data", bus.mv_data, v);
         if (k < 4) tick();
      end
      check("stall_no_accept", obs_q.size() - obs_base, 0);
      ready_manual = 1'b1;
      tick();
      tick();
      check("stall_accepted", obs_q.size() - obs_base, 1);
      ready_mode = 0;
      finish_list();

      // sq_done held low: no FIFO reads until it rises
      fifo_q.delete();
      fifo_q.push_back(rand_word(4, 1'b0));
      fifo_q.push_back(rand_word(0, 1'b1));
      start_list(-1);
      repeat (10) tick();
      check("no_rden_before_done", rden_cnt - fifo_base, 0);
      check("wait_busy", bus.busy, 1);
      bus.sq_done = 1'b1;
      tick();
      check("rden_after_sq_done", bus.fifo_rden, 1);
      finish_list();

      // No end marker: overflow after MAX_WORDS words
      fifo_q.delete();
      for (int i = 0; i < 3; i++) fifo_q.push_back(rand_word(3, 1'b0));
      start_list(2);
      finish_list();
      check("overflow_set", bus.overflow, 1);

      // All slots valid across two words: counter saturates
      fifo_q.delete();
      for (int i = 0; i < 3; i++) fifo_q.push_back(rand_word(8, 1'b0));
      start_list(0);
      finish_list();

      // Reset during EMIT
      ready_mode = 2;
      ready_manual = 1'b0;
      fifo_q.delete();
      fifo_q.push_back(rand_word(5, 1'b0));
      fifo_q.push_back(rand_word(0, 1'b1));
      start_list(0);
      wait_valid("emit_before_reset");
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check_all_zero("reset_mid_list");
      done_base = done_cnt;
      repeat (3) tick();
      reset_n = 1'b1;
      bus.sq_done = 1'b0;
      repeat (5) tick();
      check("no_done_after_reset", done_cnt - done_base, 0);
      ready_mode = 0;
      fifo_q.delete();
      fifo_q.push_back(rand_word(5, 1'b0));
      fifo_q.push_back(rand_word(0, 1'b1));
      start_list(1);
      finish_list();

      // start pulsed while busy is ignored
      ready_mode = 1;
      fifo_q.delete();
      fifo_q.push_back(rand_word(6, 1'b0));
      fifo_q.push_back(rand_word(6, 1'b0));
      start_list(0);
      wait_valid("emit_before_restart");
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("busy_after_ignored_start", bus.busy, 1);
      finish_list();

      // Randomized lists
      for (int n = 0; n < 30; n++) begin
         int nw;
         int dens;
         ready_mode = $urandom_range(0, 1);
         dens = $urandom_range(1, 8);
         nw = $urandom_range(0, 2);
         fifo_q.delete();
         for (int i = 0; i < nw; i++) fifo_q.push_back(rand_word(dens, 1'b0));
         if (nw < 2 || $urandom_range(0, 1) == 1) fifo_q.push_back(rand_word(0, 1'b1));
         fifo_q.push_back(rand_word(dens, 1'b0));
         start_list($urandom_range(0, 5));
         finish_list();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
